btn_debounce: RTL
=================

# btn_debounce

Synchronises, debounces and edge-detects the ULX3S push-buttons before they reach the game logic. Sits between the board `btn[6:0]` pins and the `topEntity` BTN input, in the 25 MHz pixel domain. Produces a clean level, one-cycle press/release pulses, and a per-frame latched press snapshot so the game samples each press exactly once per video frame.

## Interface

- `N_BTN`, 7, number of buttons.
- `DEBOUNCE_CYCLES`, 250000, required stable time in clocks (10 ms at 25 MHz); legal range 2..2^24-1.
- `INVERT_MASK`, 7'b0000001, per-bit polarity; a 1 inverts that raw input (btn[0]/PWR is active-low).

- `clk_25mhz`  in  1  pixel clock, all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `btn_raw`  in  N_BTN  asynchronous raw button pins.
- `frame_start`  in  1  one-cycle pulse at start of vertical blanking.
- `btn_level`  out  N_BTN  debounced level, 1 = pressed.
- `btn_press`  out  N_BTN  one-cycle pulse on debounced 0→1.
- `btn_release`  out  N_BTN  one-cycle pulse on debounced 1→0.
- `btn_frame`  out  N_BTN  presses seen during previous frame, held constant for one frame.

## Operation

- Polarity: `p[i] = btn_raw[i] ^ INVERT_MASK[i]`, then a two-flop synchroniser (`s1`, `s2`), both reset to 0.
- Per button, an independent counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES)`, plus a 2-state FSM:
  - STABLE: `s2 == btn_level`; `cnt` held at 0. On `s2 != btn_level`, `cnt` ← 1, enter COUNTING.
  - COUNTING: if `s2 == btn_level` (bounce), `cnt` ← 0, return to STABLE. Else if `cnt == DEBOUNCE_CYCLES-1`, `btn_level` ← `s2`, `cnt` ← 0, assert `btn_press` (rising) or `btn_release` (falling) for that cycle, return to STABLE. Else `cnt` ← `cnt + 1`.
- Counter never wraps; terminal compare is exact equality.
- Frame latch: internal `pending[i]` is set by `btn_press[i]`. On `frame_start`: `btn_frame` ← `pending | btn_press`, `pending` ← 0. A press on the same cycle as `frame_start` goes into this snapshot, not the next.
- Press and release of one button inside a single frame still yields `btn_frame[i] = 1`.
- Buttons are fully independent; simultaneous transitions on several bits are handled in parallel.

## Timing

- All outputs registered. Reset values: `btn_level` = 0, `btn_press` = 0, `btn_release` = 0, `btn_frame` = 0, all `cnt` = 0, `pending` = 0, FSMs in STABLE.
- Latency: raw change first sampled at edge E0 → `s2` updates at E1 → `btn_level` and pulse update at edge E(DEBOUNCE_CYCLES+1), i.e. DEBOUNCE_CYCLES+2 clocks.
- Any bounce shorter than DEBOUNCE_CYCLES consecutive clocks of `s2` produces no output change.
- `btn_press` / `btn_release` are high for exactly one cycle; never both high on one bit.
- `btn_frame` changes only on the edge where `frame_start` = 1.
- Reset mid-count: counters cleared, no pulse emitted. A button held through reset re-debounces and emits `btn_press` DEBOUNCE_CYCLES+2 clocks after `reset` deasserts.
- `frame_start` during reset is ignored.

## Test plan

- Clean press, DEBOUNCE_CYCLES=4, raw bit 3 0→1 held: `btn_level[3]` rises on the 6th edge, `btn_press[3]` = 1 for exactly that cycle, other bits stay 0.
- Bounce: bit 3 toggles high 3 clocks, low 1, high 3, low: no `btn_level`/`btn_press` change. Then held high 10 clocks: a single press pulse.
- Polarity: bit 0 held low from reset release with INVERT_MASK=7'b0000001 → `btn_level[0]` = 1 after 6 clocks; held high → stays 0.
- Frame latch: press bit 3, release, then `frame_start` → `btn_frame` = 7'b0001000 for the whole next frame. The following `frame_start` with no press → 0.
- Coincidence: `btn_press[5]` and `frame_start` on the same cycle → `btn_frame[5]` = 1 immediately; the next frame's snapshot has `btn_frame[5]` = 0.
- Reset mid-count: assert `reset` at cnt=2 while bit 1 is held → no pulse. After release, `btn_press[1]` occurs 6 clocks later.

Source files
------------

// File: rtl/btn_debounce_if.sv
// ---------------------------------------------------------------------------
// btn_debounce_if
//
// Bundles the board-side button pins, the video frame marker and the cleaned
// button outputs that travel between the board wrapper and the game logic.
//
// Signals:
//   btn_raw     [N_BTN]  raw, asynchronous button pins
//   frame_start [1]      one-cycle pulse at the start of vertical blanking
//   btn_level   [N_BTN]  debounced level, 1 = pressed
//   btn_press   [N_BTN]  one-cycle pulse on a debounced 0->1 transition
//   btn_release [N_BTN]  one-cycle pulse on a debounced 1->0 transition
//   btn_frame   [N_BTN]  presses seen during the previous video frame
//
// Modports:
//   master  board / video side: drives pins and frame_start, reads results
//   slave   the debouncer itself
// ---------------------------------------------------------------------------
interface btn_debounce_if #(
  parameter int N_BTN = 7
);

  logic [N_BTN-1:0] btn_raw;
  logic             frame_start;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_frame;

  modport master (
    output btn_raw,
    output frame_start,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_frame
  );

  modport slave (
    input  btn_raw,
    input  frame_start,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_frame
  );

endinterface

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Synchronises, debounces and edge-detects the ULX3S push-buttons in the
// 25 MHz pixel domain. Each button is handled by an independent two-state
// debouncer with its own stability counter. The module also keeps a per-frame
// snapshot of presses so the game logic samples every press exactly once per
// video frame.
//
// Parameters:
//   N_BTN            number of buttons
//   DEBOUNCE_CYCLES  clocks a new synchronised level must persist (2..2^24-1)
//   INVERT_MASK      per-bit polarity; a 1 inverts that raw input
//
// Ports:
//   clk_25mhz  pixel clock, all logic on its rising edge
//   reset      synchronous, active-high
//   bus        btn_debounce_if slave modport (raw pins, frame_start and the
//              level / press / release / frame outputs)
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int               N_BTN           = 7,
  parameter int               DEBOUNCE_CYCLES = 250000,
  parameter logic [N_BTN-1:0] INVERT_MASK     = {{(N_BTN-1){1'b0}}, 1'b1}
) (
  input  logic           clk_25mhz,
  input  logic           reset,
  btn_debounce_if.slave  bus
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 bits are enough
  // and the terminal compare is an exact match (no wrap is ever needed).
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_e;

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] frame_q, frame_d;

  db_state_e        state_q [N_BTN];
  db_state_e        state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];

  // Polarity correction happens before the synchroniser so everything
  // downstream sees 1 = pressed.
  always_comb begin
    s1_d = bus.btn_raw ^ INVERT_MASK;
    s2_d = s1_q;
  end

  // Per-button debouncer. A candidate level must be seen on s2 for
  // DEBOUNCE_CYCLES consecutive clocks; any return to the current level
  // abandons the attempt. Press/release pulses come out of the same decision
  // that updates the level, so they can never both be high on one bit.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE: begin
          cnt_d[i] = '0;
          if (s2_q[i] != level_q[i]) begin
            cnt_d[i]   = CNT_ONE;
            state_d[i] = COUNTING;
          end
        end
        COUNTING: begin
          if (s2_q[i] == level_q[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = STABLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            level_d[i]   = s2_q[i];
            press_d[i]   = s2_q[i];
            release_d[i] = ~s2_q[i];
            cnt_d[i]     = '0;
            state_d[i]   = STABLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = STABLE;
        end
      endcase
    end
  end

  // Frame latch. The press pulse visible in the same cycle as frame_start is
  // folded straight into the snapshot rather than into the next frame's
  // pending set, so a press is never counted twice or lost.
  always_comb begin
    frame_d   = frame_q;
    pending_d = pending_q | press_q;
    if (bus.frame_start) begin
      frame_d   = pending_q | press_q;
      pending_d = '0;
    end
  end

  // Single register stage for every piece of state. Reset has priority, so a
  // frame_start seen during reset is ignored and an in-flight count is lost
  // without emitting a pulse.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      pending_q <= '0;
      frame_q   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_frame   = frame_q;

endmodule
